// File: rtl/zebra_stripe_scanner.sv
// Zebra-crossing estimator: counts qualifying white runs along evenly
// spaced scan lines of the binarised pixel BRAM and publishes a frame verdict.
module zebra_stripe_scanner #(
    parameter int IMG_WIDTH      = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int BORDER         = 20,
    parameter int NUM_LINES      = 8,
    parameter int MIN_RUN        = 4,
    parameter int MAX_RUN        = 120,
    parameter int MIN_STRIPES    = 3,
    parameter int LINES_REQUIRED = 2,
    parameter int READ_LATENCY   = 1,
    parameter int SCAN_VERTICAL  = 0
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic                                    valid_to_read,
    input  logic                                    abort,
    output logic [$clog2(IMG_WIDTH*IMG_HEIGHT)-1:0] bram_addr,
    input  logic [1:0]                              bram_data,
    output logic                                    busy,
    output logic                                    detection_valid,
    output logic                                    crossing_detected,
    output logic [7:0]                              stripe_count,
    output logic [$clog2(NUM_LINES+1)-1:0]          lines_hit
);

    localparam int AW       = $clog2(IMG_WIDTH*IMG_HEIGHT);
    localparam int LW       = $clog2(NUM_LINES+1);
    localparam int RW       = $clog2(MAX_RUN+2);
    localparam int DW       = $clog2(READ_LATENCY+1);
    localparam int LINE_LEN = (SCAN_VERTICAL != 0) ? IMG_HEIGHT - 2*BORDER
                                                   : IMG_WIDTH - 2*BORDER;
    localparam int STEP     = (SCAN_VERTICAL != 0) ? (IMG_WIDTH - 2*BORDER) / NUM_LINES
                                                   : (IMG_HEIGHT - 2*BORDER) / NUM_LINES;
    localparam int PW       = $clog2(LINE_LEN+1);
    localparam int ADDR_INC = (SCAN_VERTICAL != 0) ? IMG_WIDTH : 1;
    localparam int LINE_INC = (SCAN_VERTICAL != 0) ? STEP : STEP*IMG_WIDTH;
    localparam int BASE     = BORDER*IMG_WIDTH + BORDER;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, LINE_END} state_t;

    state_t state_q, state_d;

    logic [LW-1:0] line_idx;
    logic [PW-1:0] pix_cnt;
    logic [DW-1:0] drain_cnt;
    logic [AW-1:0] line_base;
    logic [LW-1:0] hit_cnt;
    logic [7:0]    max_cnt;
    logic [7:0]    line_cnt;
    logic [RW-1:0] run_len;
    logic          run_trunc;

    logic [READ_LATENCY-1:0] tag_v, tag_f, tag_l;

    logic          start, pix_last, drain_last, last_line, publish;
    logic          white, consume;
    logic [LW-1:0] hit_nxt;
    logic [7:0]    max_nxt;

    assign start      = (state_q == IDLE) && valid_to_read && !abort;
    assign pix_last   = pix_cnt == PW'(LINE_LEN-1);
    assign drain_last = drain_cnt == DW'(READ_LATENCY-1);
    assign last_line  = line_idx == LW'(NUM_LINES-1);
    assign publish    = (state_q == LINE_END) && !abort && last_line;
    assign white      = |bram_data;
    assign consume    = tag_v[READ_LATENCY-1];
    assign hit_nxt    = hit_cnt + LW'(32'(line_cnt) >= MIN_STRIPES);
    assign max_nxt    = (line_cnt > max_cnt) ? line_cnt : max_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (start) state_d = ISSUE;
            ISSUE:    if (abort) state_d = IDLE;
                      else if (pix_last) state_d = DRAIN;
            DRAIN:    if (abort) state_d = IDLE;
                      else if (drain_last) state_d = LINE_END;
            LINE_END: if (abort || last_line) state_d = IDLE;
                      else state_d = ISSUE;
        endcase
    end

    always_comb begin
        busy = state_q != IDLE;
    end

    // Tags travel with each address so returning data knows its position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            tag_f <= '0;
            tag_l <= '0;
        end else begin
            if (state_q == IDLE) tag_v <= '0;
            else begin
                tag_v[0] <= state_q == ISSUE;
                for (int i = 1; i < READ_LATENCY; i++) tag_v[i] <= tag_v[i-1];
            end
            tag_f[0] <= pix_cnt == '0;
            tag_l[0] <= pix_last;
            for (int i = 1; i < READ_LATENCY; i++) begin
                tag_f[i] <= tag_f[i-1];
                tag_l[i] <= tag_l[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_idx  <= '0;
            pix_cnt   <= '0;
            drain_cnt <= '0;
            line_base <= '0;
            bram_addr <= '0;
            hit_cnt   <= '0;
            max_cnt   <= '0;
        end else if (start) begin
            line_idx  <= '0;
            pix_cnt   <= '0;
            drain_cnt <= '0;
            line_base <= AW'(BASE);
            bram_addr <= AW'(BASE);
            hit_cnt   <= '0;
            max_cnt   <= '0;
        end else if (!abort) begin
            unique case (state_q)
                IDLE: ;
                ISSUE: begin
                    pix_cnt <= pix_cnt + PW'(1);
                    if (!pix_last) bram_addr <= bram_addr + AW'(ADDR_INC);
                end
                DRAIN: drain_cnt <= drain_cnt + DW'(1);
                LINE_END: begin
                    hit_cnt   <= hit_nxt;
                    max_cnt   <= max_nxt;
                    pix_cnt   <= '0;
                    drain_cnt <= '0;
                    if (!last_line) begin
                        line_idx  <= line_idx + LW'(1);
                        line_base <= line_base + AW'(LINE_INC);
                        bram_addr <= line_base + AW'(LINE_INC);
                    end
                end
            endcase
        end
    end

    // Runs touching either end of the line are truncated and never qualify.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_len   <= '0;
            run_trunc <= 1'b0;
            line_cnt  <= '0;
        end else if (start || state_q == LINE_END) begin
            run_len   <= '0;
            run_trunc <= 1'b0;
            line_cnt  <= '0;
        end else if (consume) begin
            if (white) begin
                if (tag_l[READ_LATENCY-1]) run_len <= '0;
                else begin
                    if (run_len != RW'(MAX_RUN+1)) run_len <= run_len + RW'(1);
                    if (run_len == '0) run_trunc <= tag_f[READ_LATENCY-1];
                end
            end else if (run_len != '0) begin
                if (!run_trunc && 32'(run_len) >= MIN_RUN &&
                    32'(run_len) <= MAX_RUN && line_cnt != 8'hFF)
                    line_cnt <= line_cnt + 8'd1;
                run_len <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            detection_valid   <= 1'b0;
            crossing_detected <= 1'b0;
            stripe_count      <= '0;
            lines_hit         <= '0;
        end else begin
            detection_valid <= publish;
            if (publish) begin
                stripe_count      <= max_nxt;
                lines_hit         <= hit_nxt;
                crossing_detected <= 32'(hit_nxt) >= LINES_REQUIRED;
            end
        end
    end

endmodule

// File: tb/tb_zebra_stripe_scanner.sv
// Bench for zebra_stripe_scanner: a row scanner (latency 1) and a column
// scanner (latency 2) share one image and are checked against a run model.
module tb_zebra_stripe_scanner;

    localparam int IMG_W = 640;
    localparam int IMG_H = 480;
    localparam int BRD   = 20;
    localparam int NL    = 8;
    localparam int MINR  = 4;
    localparam int MAXR  = 120;
    localparam int MINS  = 3;
    localparam int LREQ  = 2;
    localparam int N_PIX = IMG_W*IMG_H;
    localparam int BASE  = BRD*IMG_W + BRD;
    localparam int DONE_H = NL*((IMG_W - 2*BRD) + 1 + 1) + 1;
    localparam int DONE_V = NL*((IMG_H - 2*BRD) + 2 + 1) + 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_to_read;
    logic        abort;
    logic [18:0] addr_h, addr_v;
    logic [1:0]  data_h, data_v;
    logic        busy_h, busy_v, dv_h, dv_v, cd_h, cd_v;
    logic [7:0]  sc_h, sc_v;
    logic [3:0]  lh_h, lh_v;

    logic [1:0] img [0:N_PIX-1];
    logic [1:0] pipe_h [0:3];
    logic [1:0] pipe_v [0:3];

    int n_tests = 0;
    int n_fail  = 0;
    int prev_sc_h = 0, prev_lh_h = 0, prev_sc_v = 0, prev_lh_v = 0;

    always #5 clk = ~clk;

    zebra_stripe_scanner u_h (
        .clk(clk), .rst_n(rst_n), .valid_to_read(valid_to_read),
        .abort(abort), .bram_addr(addr_h), .bram_data(data_h),
        .busy(busy_h), .detection_valid(dv_h),
        .crossing_detected(cd_h), .stripe_count(sc_h), .lines_hit(lh_h)
    );

    zebra_stripe_scanner #(.READ_LATENCY(2), .SCAN_VERTICAL(1)) u_v (
        .clk(clk), .rst_n(rst_n), .valid_to_read(valid_to_read),
        .abort(abort), .bram_addr(addr_v), .bram_data(data_v),
        .busy(busy_v), .detection_valid(dv_v),
        .crossing_detected(cd_v), .stripe_count(sc_v), .lines_hit(lh_v)
    );

    always @(posedge clk) begin
        pipe_h[0] <= img[addr_h];
        pipe_v[0] <= img[addr_v];
        for (int i = 1; i < 4; i++) begin
            pipe_h[i] <= pipe_h[i-1];
            pipe_v[i] <= pipe_v[i-1];
        end
    end
    assign data_h = pipe_h[0];
    assign data_v = pipe_v[1];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic clear_img();
        for (int i = 0; i < N_PIX; i++) img[i] = 2'b00;
    endtask

    task automatic rect(input int x0, input int x1, input int y0, input int y1,
                        input logic [1:0] v);
        for (int y = (y0 < 0 ? 0 : y0); y <= y1 && y < IMG_H; y++)
            for (int x = (x0 < 0 ? 0 : x0); x <= x1 && x < IMG_W; x++)
                img[y*IMG_W + x] = v;
    endtask

    // Reference: gather each scan line, pad with black, list white runs.
    task automatic model(input bit vert, output int sc, output int lh);
        int len, step, fixed, cnt, run, st, a;
        bit w;
        len  = vert ? IMG_H - 2*BRD : IMG_W - 2*BRD;
        step = vert ? (IMG_W - 2*BRD)/NL : (IMG_H - 2*BRD)/NL;
        sc = 0;
        lh = 0;
        for (int k = 0; k < NL; k++) begin
            fixed = BRD + k*step;
            cnt = 0;
            run = 0;
            st  = 0;
            for (int i = 0; i <= len; i++) begin
                w = 1'b0;
                if (i < len) begin
                    a = vert ? (BRD+i)*IMG_W + fixed : fixed*IMG_W + BRD + i;
                    w = img[a] != 2'b00;
                end
                if (w) begin
                    if (run == 0) st = i;
                    run++;
                end else if (run > 0) begin
                    if (st > 0 && st + run < len && run >= MINR && run <= MAXR)
                        cnt++;
                    run = 0;
                end
            end
            if (cnt > 255) cnt = 255;
            if (cnt >= MINS) lh++;
            if (cnt > sc) sc = cnt;
        end
    endtask

    task automatic rand_frame();
        int wt [8];
        int n, x0, y0, w, h;
        wt = '{3, 4, 5, 20, 119, 120, 121, 0};
        clear_img();
        n = $urandom_range(3, 14);
        for (int j = 0; j < n; j++) begin
            w = wt[$urandom_range(0, 7)];
            if (w == 0) w = $urandom_range(1, 140);
            x0 = $urandom_range(0, IMG_W-1);
            y0 = $urandom_range(0, IMG_H-1);
            h  = $urandom_range(1, IMG_H);
            rect(x0, x0+w-1, y0, y0+h-1, 2'($urandom_range(1, 3)));
        end
        n = $urandom_range(0, 6);
        for (int j = 0; j < n; j++) begin
            h = wt[$urandom_range(0, 7)];
            if (h == 0) h = $urandom_range(1, 140);
            x0 = $urandom_range(0, IMG_W-1);
            y0 = $urandom_range(0, IMG_H-1);
            w  = $urandom_range(1, IMG_W);
            rect(x0, x0+w-1, y0, y0+h-1, 2'($urandom_range(1, 3)));
        end
    endtask

    task automatic cols(input int y0, input int y1);
        for (int k = 0; k < 14; k++) rect(40+40*k, 59+40*k, y0, y1, 2'b01);
    endtask

    task automatic run_frame(input string tag, input int abort_at,
                             input int pulse_at);
        int esc_h, elh_h, esc_v, elh_v;
        int nh, nv, cyc_h, cyc_v, last;
        model(1'b0, esc_h, elh_h);
        model(1'b1, esc_v, elh_v);
        nh = 0; nv = 0; cyc_h = 0; cyc_v = 0;
        last = (abort_at > 0) ? abort_at + 200 : DONE_H + 3;
        @(negedge clk);
        valid_to_read = 1'b1;
        @(posedge clk);
        #1 valid_to_read = 1'b0;
        for (int c = 1; c <= last; c++) begin
            @(negedge clk);
            if (c == 1) begin
                chk({tag, ".busy_h"}, int'(busy_h), 1);
                chk({tag, ".busy_v"}, int'(busy_v), 1);
                chk({tag, ".addr0_h"}, int'(addr_h), BASE);
                chk({tag, ".addr0_v"}, int'(addr_v), BASE);
            end
            if (c == 2) begin
                chk({tag, ".addr1_h"}, int'(addr_h), BASE + 1);
                chk({tag, ".addr1_v"}, int'(addr_v), BASE + IMG_W);
            end
            if (c == pulse_at) valid_to_read = 1'b1;
            if (c == pulse_at + 1) valid_to_read = 1'b0;
            if (c == abort_at) abort = 1'b1;
            if (abort_at > 0 && c == abort_at + 1) begin
                abort = 1'b0;
                chk({tag, ".abort_busy_h"}, int'(busy_h), 0);
                chk({tag, ".abort_busy_v"}, int'(busy_v), 0);
            end
            if (dv_h) begin
                nh++;
                if (nh == 1) begin
                    cyc_h = c;
                    chk({tag, ".sc_h"}, int'(sc_h), esc_h);
                    chk({tag, ".lh_h"}, int'(lh_h), elh_h);
                    chk({tag, ".cd_h"}, int'(cd_h), int'(elh_h >= LREQ));
                    chk({tag, ".busy_end_h"}, int'(busy_h), 0);
                end
            end
            if (dv_v) begin
                nv++;
                if (nv == 1) begin
                    cyc_v = c;
                    chk({tag, ".sc_v"}, int'(sc_v), esc_v);
                    chk({tag, ".lh_v"}, int'(lh_v), elh_v);
                    chk({tag, ".cd_v"}, int'(cd_v), int'(elh_v >= LREQ));
                    chk({tag, ".busy_end_v"}, int'(busy_v), 0);
                end
            end
        end
        if (abort_at > 0) begin
            chk({tag, ".nstrobe_h"}, nh, 0);
            chk({tag, ".nstrobe_v"}, nv, 0);
            chk({tag, ".keep_sc_h"}, int'(sc_h), prev_sc_h);
            chk({tag, ".keep_lh_h"}, int'(lh_h), prev_lh_h);
            chk({tag, ".keep_sc_v"}, int'(sc_v), prev_sc_v);
            chk({tag, ".keep_lh_v"}, int'(lh_v), prev_lh_v);
        end else begin
            chk({tag, ".nstrobe_h"}, nh, 1);
            chk({tag, ".nstrobe_v"}, nv, 1);
            chk({tag, ".cyc_h"}, cyc_h, DONE_H);
            chk({tag, ".cyc_v"}, cyc_v, DONE_V);
            chk({tag, ".hold_sc_h"}, int'(sc_h), esc_h);
            chk({tag, ".hold_sc_v"}, int'(sc_v), esc_v);
            prev_sc_h = esc_h; prev_lh_h = elh_h;
            prev_sc_v = esc_v; prev_lh_v = elh_v;
        end
    endtask

    initial begin
        rst_n = 1'b0;
        valid_to_read = 1'b0;
        abort = 1'b0;
        clear_img();
        repeat (3) @(negedge clk);
        chk("rst.busy_h", int'(busy_h), 0);
        chk("rst.dv_h", int'(dv_h), 0);
        chk("rst.sc_h", int'(sc_h), 0);
        chk("rst.addr_v", int'(addr_v), 0);
        rst_n = 1'b1;

        run_frame("black", 0, 0);

        clear_img();
        for (int k = 0; k < 10; k++) rect(40+10*k, 42+10*k, 0, IMG_H-1, 2'b10);
        rect(200, 320, 0, IMG_H-1, 2'b11);
        run_frame("short_long", 0, 0);

        clear_img();
        cols(0, IMG_H-1);
        run_frame("columns", 0, 2000);
        run_frame("abort", 1000, 0);

        // Start requested while abort is held in IDLE must be dropped.
        @(negedge clk);
        valid_to_read = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        valid_to_read = 1'b0;
        abort = 1'b0;
        chk("idle_abort.busy_h", int'(busy_h), 0);
        chk("idle_abort.busy_v", int'(busy_v), 0);

        clear_img();
        rect(20, 30, 0, IMG_H-1, 2'b01);
        rect(600, 619, 0, IMG_H-1, 2'b01);
        rect(100, 119, 0, IMG_H-1, 2'b01);
        rect(300, 319, 0, IMG_H-1, 2'b01);
        run_frame("edges", 0, 0);

        @(negedge clk);
        valid_to_read = 1'b1;
        @(posedge clk);
        #1 valid_to_read = 1'b0;
        repeat (300) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst.busy_h", int'(busy_h), 0);
        chk("midrst.sc_h", int'(sc_h), 0);
        chk("midrst.lh_h", int'(lh_h), 0);
        chk("midrst.busy_v", int'(busy_v), 0);
        chk("midrst.sc_v", int'(sc_v), 0);
        @(negedge clk);
        chk("midrst.dv_h", int'(dv_h), 0);
        rst_n = 1'b1;
        prev_sc_h = 0; prev_lh_h = 0; prev_sc_v = 0; prev_lh_v = 0;

        clear_img();
        cols(20, 100);
        run_frame("rows20_100", 0, 0);

        clear_img();
        cols(20, 50);
        run_frame("rows20_50", 0, 0);

        clear_img();
        for (int k = 0; k < 10; k++) rect(0, IMG_W-1, 40+40*k, 59+40*k, 2'b01);
        run_frame("bands", 0, 0);

        for (int r = 0; r < 3; r++) begin
            rand_frame();
            run_frame($sformatf("rand%0d", r), 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
